wash_phase_timer: RTL
=====================

// Module: wash_phase_timer
// PURPOSE
// - Parametrised countdown timer for washing-machine programme phases (fill, wash, rinse, spin).
// - Loads a phase duration and scales it by the clock-frequency select, then counts down on prescaled ticks.
// - Supports pause/resume, abort, restart and saturating scaling; flags phase completion to the programme FSM.
// PARAMETERS
// - CNT_W     32  width of duration value and remaining counter
// - FSEL_W    2   width of ClkFreq; scale shift = ClkFreq (0..2^FSEL_W-1)
// - TICK_DIV  1   clk cycles per count tick (>=1); 1 = decrement every RUN cycle
// PORTS
// - clk        in   1       system clock, all logic on rising edge
// - rst        in   1       asynchronous reset, active-high
// - start      in   1       load value, begin phase (also restarts a running phase)
// - pause      in   1       level; freezes counter and prescaler while high in RUN
// - abort      in   1       drop phase, return to IDLE, no done
// - ClkFreq    in   FSEL_W  duration scale: count = value << ClkFreq
// - value      in   CNT_W   phase duration in ticks, sampled only when start=1
// - remaining  out  CNT_W   ticks left in current phase
// - busy       out  1       1 in RUN or PAUSED
// - paused     out  1       1 in PAUSED
// - done       out  1       level, 1 in DONE until next start/abort
// - done_pulse out  1       one-cycle pulse on entry to DONE
// - sat        out  1       1 if last load saturated; updated on every start
// BEHAVIOUR
// - Reset (async, any state): state=IDLE, remaining=0, prescaler=0, all flags 0.
// - States: IDLE, RUN, PAUSED, DONE. Registered outputs, no combinational in->out paths.
// - Priority on same edge: abort > start > pause > tick.
// - abort: any state -> IDLE; remaining=0, done/done_pulse/sat unchanged except done=0.
// - start: any state -> load scaled=value<<ClkFreq; prescaler=0; done=0.
//   - scaled computed in CNT_W bits; if any of top ClkFreq bits of value set -> scaled=all-ones, sat=1, else sat=0.
//   - scaled==0 -> DONE next edge (done=1, done_pulse=1); else RUN, remaining=scaled.
// - RUN: tick when prescaler==TICK_DIV-1 and pause=0; prescaler wraps to 0 on tick.
//   - tick with remaining>1: remaining-1.
//   - tick with remaining==1: remaining=0, -> DONE, done=1, done_pulse=1 for exactly one cycle.
//   - pause=1: -> PAUSED; prescaler and remaining hold.
// - PAUSED: pause=0 -> RUN, counting resumes from held prescaler (no tick lost/added).
// - DONE: hold remaining=0, done=1; done_pulse low after first cycle; pause ignored.
// - IDLE: pause ignored; outputs hold.
// - Latency (TICK_DIV=1): start sampled at edge E with value V -> done_pulse high after edge E+(V<<ClkFreq).
// - Total RUN clocks for a phase = scaled*TICK_DIV, excluding PAUSED cycles.
// - No wrap: remaining never decrements below 0.
// TESTING
// - TICK_DIV=1, ClkFreq=0, value=3, start at E0 -> remaining 3,2,1,0 after E1..E3; done_pulse 1 only after E3.
// - ClkFreq=3, value=5 -> remaining=40 after start, done after 40 ticks; sat=0.
// - CNT_W=32, value=32'h2000_0001, ClkFreq=3 -> remaining=32'hFFFF_FFFF, sat=1.
// - value=10, pause high 4 cycles after 3 ticks -> remaining holds 7 during pause; done 4 cycles later than unpaused.
// - TICK_DIV=4, value=2 -> done_pulse 8 clocks after start; restart at remaining=1 with value=6 -> remaining=6, no done_pulse.
// - abort and start same edge in RUN -> IDLE, remaining=0; rst asserted mid-RUN -> all outputs 0 immediately, IDLE.

Source files
------------

// File: rtl/wash_phase_timer.sv
// Countdown timer for one washing-machine programme phase. The load is value << ClkFreq,
// saturating to all-ones. It counts down on prescaled ticks, with pause, abort and restart.
module wash_phase_timer #(
   parameter int CNT_W    = 32,
   parameter int FSEL_W   = 2,
   parameter int TICK_DIV = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              pause,
   input  logic              abort,
   input  logic [FSEL_W-1:0] ClkFreq,
   input  logic [CNT_W-1:0]  value,
   output logic [CNT_W-1:0]  remaining,
   output logic              busy,
   output logic              paused,
   output logic              done,
   output logic              done_pulse,
   output logic              sat
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_DONE} state_t;

   localparam int MAXSH = (1 << FSEL_W) - 1;
   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
   localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // Result MSB is the saturation flag; lower CNT_W bits are the clamped scaled count.
   function automatic logic [CNT_W:0] scale_sat(input logic [CNT_W-1:0] v,
                                                input logic [FSEL_W-1:0] sh);
      logic [CNT_W+MAXSH-1:0] wide;
      wide = {{MAXSH{1'b0}}, v} << sh;
      if (|wide[CNT_W+MAXSH-1:CNT_W])
         return {1'b1, {CNT_W{1'b1}}};
      else
         return {1'b0, wide[CNT_W-1:0]};
   endfunction

   state_t             state;
   logic [PRE_W-1:0]   presc;
   logic [CNT_W:0]     load;
   logic               tick_due;

   assign load     = scale_sat(value, ClkFreq);
   assign tick_due = (presc == PRE_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         presc      <= '0;
         remaining  <= '0;
         busy       <= 1'b0;
         paused     <= 1'b0;
         done       <= 1'b0;
         done_pulse <= 1'b0;
         sat        <= 1'b0;
      end else begin
         done_pulse <= 1'b0;
         if (abort) begin
            state     <= S_IDLE;
            presc     <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            paused    <= 1'b0;
            done      <= 1'b0;
         end else if (start) begin
            presc     <= '0;
            sat       <= load[CNT_W];
            remaining <= load[CNT_W-1:0];
            paused    <= 1'b0;
            if (load[CNT_W-1:0] == '0) begin
               state      <= S_DONE;
               busy       <= 1'b0;
               done       <= 1'b1;
               done_pulse <= 1'b1;
            end else begin
               state <= S_RUN;
               busy  <= 1'b1;
               done  <= 1'b0;
            end
         end else begin
            case (state)
               // The resume edge out of PAUSED counts like a normal RUN cycle, so no tick is lost.
               S_RUN, S_PAUSED: begin
                  if (pause) begin
                     state  <= S_PAUSED;
                     paused <= 1'b1;
                  end else begin
                     state  <= S_RUN;
                     paused <= 1'b0;
                     if (tick_due) begin
                        presc <= '0;
                        if (remaining <= CNT_ONE) begin
                           remaining  <= '0;
                           state      <= S_DONE;
                           busy       <= 1'b0;
                           done       <= 1'b1;
                           done_pulse <= 1'b1;
                        end else begin
                           remaining <= remaining - CNT_ONE;
                        end
                     end else begin
                        presc <= presc + PRE_ONE;
                     end
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule
